// File: rtl/ascon_share_serializer.sv
// ----------------------------------------------------------------------------
// ascon_share_serializer
//
// Multi-share word serializer for the masked ASCON datapath. One WORD_SIZE
// word per share is accepted in lockstep and then emitted SHIFT_WIDTH bits
// per share per beat. Each share is zero-padded up to a whole number of beats.
// There are two stages: an active shift register that is draining, and one
// pending buffer. The pending buffer lets the next word set be accepted while
// the current one drains, so consecutive words leave with no bubble.
//
// Ports:
//   clk        clock
//   reset_n    asynchronous active-low reset
//   flush      synchronous clear of both stages, overrides every handshake
//   in_valid   input word set valid
//   in_ready   a word set can be accepted (registered, = !pending_valid)
//   in_data    share i at [i*WORD_SIZE +: WORD_SIZE]
//   out_valid  out_data holds a valid beat
//   out_ready  consumer takes the beat
//   out_data   share i slice at [i*SHIFT_WIDTH +: SHIFT_WIDTH]
//   out_last   current beat is the final beat of the word set
//   out_beat   index of the current beat, 0..NUM_BEATS-1
// ----------------------------------------------------------------------------
module ascon_share_serializer #(
    parameter int WORD_SIZE    = 64,
    parameter int SHIFT_WIDTH  = 4,
    parameter int NUM_SHARES   = 2,
    parameter int MSB_FIRST    = 0,
    localparam int NUM_BEATS    = (WORD_SIZE + SHIFT_WIDTH - 1) / SHIFT_WIDTH,
    localparam int PADDED_WIDTH = NUM_BEATS * SHIFT_WIDTH,
    localparam int CNT_W        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_SHARES*WORD_SIZE-1:0]   in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_SHARES*SHIFT_WIDTH-1:0] out_data,
    output logic                              out_last,
    output logic [CNT_W-1:0]                  out_beat
);

    localparam int              PAD_BITS  = PADDED_WIDTH - WORD_SIZE;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    logic [NUM_SHARES-1:0][PADDED_WIDTH-1:0] active_q, active_d;
    logic [NUM_SHARES-1:0][PADDED_WIDTH-1:0] pend_q, pend_d;
    logic                                    active_valid_q, active_valid_d;
    logic                                    pend_valid_q, pend_valid_d;
    logic [CNT_W-1:0]                        beat_q, beat_d;

    logic [NUM_SHARES-1:0][PADDED_WIDTH-1:0] load_lanes;
    logic [NUM_SHARES-1:0][PADDED_WIDTH-1:0] shift_lanes;

    logic in_fire;
    logic out_fire;
    logic last_beat;
    logic active_free;

    // Per-share padding, shifting and output slicing. The output end of the
    // register is the LSB end for LSB-first order and the MSB end otherwise;
    // padding always sits at the opposite end so it leaves in the final beat.
    for (genvar gi = 0; gi < NUM_SHARES; gi++) begin : g_share
        if (MSB_FIRST != 0) begin : g_msb
            assign load_lanes[gi]  = PADDED_WIDTH'(in_data[gi*WORD_SIZE +: WORD_SIZE]) << PAD_BITS;
            assign shift_lanes[gi] = active_q[gi] << SHIFT_WIDTH;
            assign out_data[gi*SHIFT_WIDTH +: SHIFT_WIDTH] =
                active_q[gi][PADDED_WIDTH-1 -: SHIFT_WIDTH];
        end else begin : g_lsb
            assign load_lanes[gi]  = PADDED_WIDTH'(in_data[gi*WORD_SIZE +: WORD_SIZE]);
            assign shift_lanes[gi] = active_q[gi] >> SHIFT_WIDTH;
            assign out_data[gi*SHIFT_WIDTH +: SHIFT_WIDTH] =
                active_q[gi][SHIFT_WIDTH-1:0];
        end
    end

    // in_ready depends only on state, never on out_ready.
    assign in_ready  = !pend_valid_q;
    assign out_valid = active_valid_q;
    assign last_beat = (beat_q == LAST_BEAT);
    assign out_last  = active_valid_q && last_beat;
    assign out_beat  = beat_q;

    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;
    // Active stage is (or becomes) empty at this edge.
    assign active_free = !active_valid_q || (out_fire && last_beat);

    always_comb begin
        active_d       = active_q;
        active_valid_d = active_valid_q;
        pend_d         = pend_q;
        pend_valid_d   = pend_valid_q;
        beat_d         = beat_q;

        if (flush) begin
            active_d       = '0;
            active_valid_d = 1'b0;
            pend_d         = '0;
            pend_valid_d   = 1'b0;
            beat_d         = '0;
        end else begin
            if (out_fire) begin
                if (last_beat) begin
                    // Completion: promote the pending word, or clear the
                    // register so out_data reads zero while idle.
                    if (pend_valid_q) begin
                        active_d       = pend_q;
                        active_valid_d = 1'b1;
                        pend_d         = '0;
                        pend_valid_d   = 1'b0;
                    end else begin
                        active_d       = '0;
                        active_valid_d = 1'b0;
                    end
                    beat_d = '0;
                end else begin
                    active_d = shift_lanes;
                    beat_d   = beat_q + CNT_W'(1);
                end
            end

            // in_fire implies pending is empty, so it never collides with a
            // pending-to-active promotion.
            if (in_fire) begin
                if (active_free && !pend_valid_q) begin
                    active_d       = load_lanes;
                    active_valid_d = 1'b1;
                    beat_d         = '0;
                end else begin
                    pend_d       = load_lanes;
                    pend_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q       <= '0;
            active_valid_q <= 1'b0;
            pend_q         <= '0;
            pend_valid_q   <= 1'b0;
            beat_q         <= '0;
        end else begin
            active_q       <= active_d;
            active_valid_q <= active_valid_d;
            pend_q         <= pend_d;
            pend_valid_q   <= pend_valid_d;
            beat_q         <= beat_d;
        end
    end

endmodule

// File: tb/tb_ascon_share_serializer.sv
// ----------------------------------------------------------------------------
// tb_ascon_share_serializer
//
// Three serializer instances (64-bit words, 2 shares):
//   k=0: SHIFT_WIDTH=4, LSB first   (16 beats)
//   k=1: SHIFT_WIDTH=5, LSB first   (13 beats, padding at the top)
//   k=2: SHIFT_WIDTH=5, MSB first   (13 beats, padding at the bottom)
// Each instance is exercised in turn. Expected beats come from a bit-level
// model of the padded word and are queued on acceptance; a monitor pops and
// compares every beat the consumer takes.
// ----------------------------------------------------------------------------
module tb_ascon_share_serializer;

    function automatic int sw_of(input int k);
        return (k == 0) ? 4 : 5;
    endfunction

    function automatic int msb_of(input int k);
        return (k == 2) ? 1 : 0;
    endfunction

    function automatic int nb_of(input int k);
        return (64 + sw_of(k) - 1) / sw_of(k);
    endfunction

    typedef struct {
        int         k;
        logic [9:0] data;
        logic       last;
        int         beat;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n   [3];
    logic         flush     [3];
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_data   [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [9:0]   out_data  [3];
    logic         out_last  [3];
    logic [3:0]   out_beat  [3];

    bit           rnd_en    [3];
    bit           stalled   [3];
    logic [9:0]   h_data    [3];
    logic         h_last    [3];
    logic [3:0]   h_beat    [3];

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        logic [2*sw_of(gi)-1:0] od;
        ascon_share_serializer #(
            .WORD_SIZE   (64),
            .SHIFT_WIDTH (sw_of(gi)),
            .NUM_SHARES  (2),
            .MSB_FIRST   (msb_of(gi))
        ) dut (
            .clk       (clk),
            .reset_n   (reset_n[gi]),
            .flush     (flush[gi]),
            .in_valid  (in_valid[gi]),
            .in_ready  (in_ready[gi]),
            .in_data   (in_data[gi]),
            .out_valid (out_valid[gi]),
            .out_ready (out_ready[gi]),
            .out_data  (od),
            .out_last  (out_last[gi]),
            .out_beat  (out_beat[gi])
        );
        assign out_data[gi] = 10'(od);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Slice b of a word as seen by the consumer. The word is placed inside a
    // PADDED-bit field (low end for LSB first, high end for MSB first) and the
    // field is read SW bits at a time starting from the output end.
    function automatic logic [4:0] slice(input logic [63:0] w, input int b, input int sw,
                                         input int msb, input int nb);
        logic [4:0] r;
        int p;
        int pos;
        r = '0;
        p = nb * sw;
        for (int j = 0; j < sw; j++) begin
            if (msb != 0) pos = (p - (b + 1) * sw + j) - (p - 64);
            else          pos = b * sw + j;
            if (pos >= 0 && pos < 64) r[j] = w[pos];
        end
        return r;
    endfunction

    task automatic push_exp(input int k, input logic [63:0] w0, input logic [63:0] w1);
        exp_t e;
        int sw;
        int nb;
        sw = sw_of(k);
        nb = nb_of(k);
        for (int b = 0; b < nb; b++) begin
            e.k    = k;
            e.data = 10'(slice(w0, b, sw, msb_of(k), nb)) |
                     (10'(slice(w1, b, sw, msb_of(k), nb)) << sw);
            e.last = (b == nb - 1);
            e.beat = b;
            exp_q.push_back(e);
        end
    endtask

    // Presents a word set and returns #1 after the accepting edge.
    task automatic send(input int k, input logic [63:0] w0, input logic [63:0] w1);
        bit acc;
        bit ok;
        ok = 0;
        in_data[k]  = {w1, w0};
        in_valid[k] = 1'b1;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            acc = in_ready[k] && !flush[k];
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1;
                break;
            end
        end
        in_valid[k] = 1'b0;
        chk($sformatf("k%0d_send_accepted", k), 64'(ok), 64'd1);
        if (ok) push_exp(k, w0, w1);
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 3000) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk({name, "_beats_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [63:0] a0, a1, b0, b1;
        int bubbles;
        bit prev_last;
        bit moved;
        int c;

        for (int k = 0; k < 3; k++) begin
            reset_n[k]   = 1'b0;
            flush[k]     = 1'b0;
            in_valid[k]  = 1'b0;
            in_data[k]   = '0;
            out_ready[k] = 1'b1;
            rnd_en[k]    = 0;
            stalled[k]   = 0;
        end

        fork
            // Monitor / scoreboard
            forever begin
                @(negedge clk);
                for (int k = 0; k < 3; k++) begin
                    if (!reset_n[k]) begin
                        stalled[k] = 0;
                        continue;
                    end
                    if (stalled[k]) begin
                        chk($sformatf("k%0d_stall_valid", k), 64'(out_valid[k]), 64'd1);
                        chk($sformatf("k%0d_stall_data", k), 64'(out_data[k]), 64'(h_data[k]));
                        chk($sformatf("k%0d_stall_last", k), 64'(out_last[k]), 64'(h_last[k]));
                        chk($sformatf("k%0d_stall_beat", k), 64'(out_beat[k]), 64'(h_beat[k]));
                    end
                    stalled[k] = 0;
                    if (out_valid[k] && out_ready[k]) begin
                        if (exp_q.size() == 0 || exp_q[0].k != k) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL k%0d_unexpected_beat: got data 0x%0h beat %0d, expected no beat (t=%0t)",
                                     k, out_data[k], out_beat[k], $time);
                        end else begin
                            exp_t e;
                            e = exp_q.pop_front();
                            chk($sformatf("k%0d_data_b%0d", k, e.beat), 64'(out_data[k]), 64'(e.data));
                            chk($sformatf("k%0d_last_b%0d", k, e.beat), 64'(out_last[k]), 64'(e.last));
                            chk($sformatf("k%0d_beat_b%0d", k, e.beat), 64'(out_beat[k]), 64'(e.beat));
                        end
                    end else if (out_valid[k] && !flush[k]) begin
                        stalled[k] = 1;
                        h_data[k]  = out_data[k];
                        h_last[k]  = out_last[k];
                        h_beat[k]  = out_beat[k];
                    end
                end
            end
            // Consumer readiness: 30% stall when randomised
            forever begin
                @(posedge clk);
                #1;
                for (int k = 0; k < 3; k++)
                    out_ready[k] = rnd_en[k] ? ($urandom_range(99) >= 30) : 1'b1;
            end
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("k%0d_rst_out_valid", k), 64'(out_valid[k]), 64'd0);
            chk($sformatf("k%0d_rst_out_data", k), 64'(out_data[k]), 64'd0);
            chk($sformatf("k%0d_rst_out_last", k), 64'(out_last[k]), 64'd0);
            chk($sformatf("k%0d_rst_out_beat", k), 64'(out_beat[k]), 64'd0);
            chk($sformatf("k%0d_rst_in_ready", k), 64'(in_ready[k]), 64'd1);
            reset_n[k] = 1'b1;
        end
        @(posedge clk);
        #1;

        for (int k = 0; k < 3; k++) begin
            // Directed word, full throughput, 1-cycle latency
            send(k, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210);
            chk($sformatf("k%0d_latency_valid", k), 64'(out_valid[k]), 64'd1);
            chk($sformatf("k%0d_latency_beat", k), 64'(out_beat[k]), 64'd0);
            drain($sformatf("k%0d_directed", k));
            chk($sformatf("k%0d_idle_valid", k), 64'(out_valid[k]), 64'd0);
            chk($sformatf("k%0d_idle_data", k), 64'(out_data[k]), 64'd0);

            // Back-to-back word sets
            a0 = {$urandom, $urandom}; a1 = {$urandom, $urandom};
            b0 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
            send(k, a0, a1);
            send(k, b0, b1);
            chk($sformatf("k%0d_b2b_pend_in_ready", k), 64'(in_ready[k]), 64'd0);
            bubbles = 0;
            prev_last = 0;
            moved = 0;
            for (c = 0; c < 200; c++) begin
                @(posedge clk);
                #1;
                if (exp_q.size() == 0) break;
                if (!out_valid[k]) bubbles++;
                if (prev_last && !moved) begin
                    chk($sformatf("k%0d_b2b_in_ready_after_move", k), 64'(in_ready[k]), 64'd1);
                    chk($sformatf("k%0d_b2b_beat0_after_move", k), 64'(out_beat[k]), 64'd0);
                    moved = 1;
                end else if (out_valid[k] && out_last[k] && !moved) begin
                    chk($sformatf("k%0d_b2b_in_ready_at_last", k), 64'(in_ready[k]), 64'd0);
                    prev_last = 1;
                end
            end
            chk($sformatf("k%0d_b2b_bubbles", k), 64'(bubbles), 64'd0);
            chk($sformatf("k%0d_b2b_move_seen", k), 64'(moved), 64'd1);
            drain($sformatf("k%0d_b2b", k));

            // Random words with random gaps and 30% consumer stalls
            rnd_en[k] = 1;
            for (int n = 0; n < 8; n++) begin
                repeat ($urandom_range(3)) @(posedge clk);
                #1;
                send(k, {$urandom, $urandom}, {$urandom, $urandom});
            end
            drain($sformatf("k%0d_random", k));
            rnd_en[k] = 0;
            @(posedge clk);
            #1;

            // Flush at beat 7 with the pending buffer full
            send(k, {$urandom, $urandom}, {$urandom, $urandom});
            send(k, {$urandom, $urandom}, {$urandom, $urandom});
            chk($sformatf("k%0d_flush_pend_full", k), 64'(in_ready[k]), 64'd0);
            c = 0;
            while (!(out_valid[k] && out_beat[k] == 4'd7) && c < 100) begin
                @(posedge clk);
                #1;
                c++;
            end
            chk($sformatf("k%0d_flush_reach_beat7", k), 64'(out_beat[k]), 64'd7);
            flush[k] = 1'b1;
            @(posedge clk);
            #1;
            flush[k] = 1'b0;
            exp_q.delete();
            chk($sformatf("k%0d_flush_out_valid", k), 64'(out_valid[k]), 64'd0);
            chk($sformatf("k%0d_flush_in_ready", k), 64'(in_ready[k]), 64'd1);
            chk($sformatf("k%0d_flush_out_data", k), 64'(out_data[k]), 64'd0);
            chk($sformatf("k%0d_flush_out_beat", k), 64'(out_beat[k]), 64'd0);
            send(k, {$urandom, $urandom}, {$urandom, $urandom});
            chk($sformatf("k%0d_post_flush_beat", k), 64'(out_beat[k]), 64'd0);
            drain($sformatf("k%0d_post_flush", k));

            // Asynchronous reset in the middle of a word
            send(k, {$urandom, $urandom}, {$urandom, $urandom});
            c = 0;
            while (out_beat[k] != 4'd5 && c < 100) begin
                @(posedge clk);
                #1;
                c++;
            end
            #2;
            reset_n[k] = 1'b0;
            #1;
            exp_q.delete();
            chk($sformatf("k%0d_arst_out_valid", k), 64'(out_valid[k]), 64'd0);
            chk($sformatf("k%0d_arst_out_data", k), 64'(out_data[k]), 64'd0);
            chk($sformatf("k%0d_arst_out_last", k), 64'(out_last[k]), 64'd0);
            chk($sformatf("k%0d_arst_out_beat", k), 64'(out_beat[k]), 64'd0);
            chk($sformatf("k%0d_arst_in_ready", k), 64'(in_ready[k]), 64'd1);
            repeat (2) @(negedge clk);
            reset_n[k] = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("k%0d_rel_in_ready", k), 64'(in_ready[k]), 64'd1);
            chk($sformatf("k%0d_rel_out_valid", k), 64'(out_valid[k]), 64'd0);
            send(k, {$urandom, $urandom}, {$urandom, $urandom});
            drain($sformatf("k%0d_post_reset", k));
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
